// File: rtl/sprite_write_sched_if.sv
// Sprite write scheduler bus: two requester write ports plus the engine write port.
// Latency: none (wires only).
// Backpressure: each requester sees its own ready; the engine port has no backpressure.
// Signals:
//   a_valid/a_ready/a_addr/a_data : CPU requester (valid/ready handshake)
//   b_valid/b_ready/b_addr/b_data : game-logic requester (valid/ready handshake)
//   wren/addr/ldr                 : register write port into the sprite engine
//   frame_done/backlog            : drain-window status
// master = requester/engine side, slave = the scheduler.
interface sprite_write_sched_if;
  logic        a_valid;
  logic        a_ready;
  logic [5:0]  a_addr;
  logic [15:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [5:0]  b_addr;
  logic [15:0] b_data;
  logic        wren;
  logic [5:0]  addr;
  logic [15:0] ldr;
  logic        frame_done;
  logic        backlog;

  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    input  a_ready, b_ready,
    input  wren, addr, ldr, frame_done, backlog
  );

  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    output a_ready, b_ready,
    output wren, addr, ldr, frame_done, backlog
  );
endinterface

// File: rtl/sprite_write_sched.sv
// Shares the sprite engine register write port between CPU (A) and game logic (B); writes drain in vblank.
// Latency: first wren one cycle after edge E+3 (E = edge where vsync rises); one write per 4 cycles.
// Backpressure: x_ready = per-requester FIFO not full (0 in reset); engine port is never stalled.
// Ports:
//   clk_50_mhz : the only clock
//   rst        : synchronous active-high reset, flushes both FIFOs
//   vsync      : vertical sync (same clock domain), high during flyback
//   bus        : sprite_write_sched_if.slave (requester handshakes, wren/addr/ldr, frame_done, backlog)
// Optional feature: define SPRITE_SCHED_BITMAP_BYPASS_EN to issue bitmap writes (addr < 6'h10)
// from IDLE without waiting for blanking.

// Circular-buffer FIFO with one extra pointer bit; full/empty decided by the MSB.
module sprite_write_sched_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 22
) (
  input  logic             clk_50_mhz,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty    = (wr_ptr == rd_ptr);
  // Same index, different lap bit: writer is a full lap ahead.
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_50_mhz) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= push_dat;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end
endmodule

module sprite_write_sched #(
  parameter int FIFO_DEPTH           = 4,
  parameter int MAX_WRITES_PER_FRAME = 8
) (
  input  logic                  clk_50_mhz,
  input  logic                  rst,
  input  logic                  vsync,
  sprite_write_sched_if.slave   bus
);
  typedef struct packed {
    logic [5:0]  addr;
    logic [15:0] data;
  } wr_req_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PICK   = 3'd1,
    SETUP  = 3'd2,
    STROBE = 3'd3,
    HOLD   = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [5:0] WMAX = 6'(MAX_WRITES_PER_FRAME);

  state_t      state;
  state_t      state_n;
  logic        vsync_q;
  logic        blank_rise;
  logic [5:0]  wcount;
  logic        last_grant_b;
  logic        bypass;
  logic        bypass_n;

  logic        wren_r;
  logic [5:0]  addr_r;
  logic [15:0] ldr_r;
  logic        frame_done_r;
  logic        backlog_r;

  wr_req_t     a_head;
  wr_req_t     b_head;
  wr_req_t     a_in;
  wr_req_t     b_in;
  logic        a_full;
  logic        a_empty;
  logic        b_full;
  logic        b_empty;
  logic        a_push;
  logic        b_push;
  logic        a_pop;
  logic        b_pop;

  logic        load;
  logic        grant_a;
  logic        rr_grant_a;
  logic        clr_wcount;
  logic        inc_wcount;

  // ---------------------------------------------------------------- requester FIFOs
  // Ready comes only from the registered full flag, so a pop in the same cycle
  // never makes room for that cycle's push.
  assign bus.a_ready = !a_full && !rst;
  assign bus.b_ready = !b_full && !rst;
  assign a_push      = bus.a_valid && bus.a_ready;
  assign b_push      = bus.b_valid && bus.b_ready;
  assign a_in        = '{addr: bus.a_addr, data: bus.a_data};
  assign b_in        = '{addr: bus.b_addr, data: bus.b_data};

  sprite_write_sched_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(wr_req_t))
  ) u_fifo_a (
    .clk_50_mhz (clk_50_mhz),
    .rst        (rst),
    .push       (a_push),
    .push_dat   (a_in),
    .pop        (a_pop),
    .head_dat   (a_head),
    .full       (a_full),
    .empty      (a_empty)
  );

  sprite_write_sched_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(wr_req_t))
  ) u_fifo_b (
    .clk_50_mhz (clk_50_mhz),
    .rst        (rst),
    .push       (b_push),
    .push_dat   (b_in),
    .pop        (b_pop),
    .head_dat   (b_head),
    .full       (b_full),
    .empty      (b_empty)
  );

  // ---------------------------------------------------------------- arbitration
  assign blank_rise = vsync && !vsync_q;

  // On a tie the side not served last wins; last_grant_b resets to 1 so A wins first.
  assign rr_grant_a = !a_empty && (b_empty || last_grant_b);

`ifdef SPRITE_SCHED_BITMAP_BYPASS_EN
  // Bitmap registers live below 6'h10; only a FIFO head can bypass so order per
  // requester is preserved (a position write at the head blocks later bitmaps).
  logic a_byp;
  logic b_byp;
  logic byp_grant_a;
  assign a_byp       = !a_empty && (a_head.addr < 6'h10);
  assign b_byp       = !b_empty && (b_head.addr < 6'h10);
  assign byp_grant_a = a_byp && (!b_byp || last_grant_b);
`endif

  assign a_pop = load && grant_a;
  assign b_pop = load && !grant_a;

  // ---------------------------------------------------------------- FSM next state
  always_comb begin
    state_n    = state;
    bypass_n   = bypass;
    load       = 1'b0;
    grant_a    = 1'b0;
    clr_wcount = 1'b0;
    inc_wcount = 1'b0;
    case (state)
      IDLE: begin
        if (blank_rise) begin
          clr_wcount = 1'b1;
          state_n    = PICK;
        end
`ifdef SPRITE_SCHED_BITMAP_BYPASS_EN
        else if (a_byp || b_byp) begin
          load     = 1'b1;
          grant_a  = byp_grant_a;
          bypass_n = 1'b1;
          state_n  = SETUP;
        end
`endif
      end
      PICK: begin
        if ((a_empty && b_empty) || (wcount == WMAX)) begin
          state_n = DONE;
        end else begin
          load     = 1'b1;
          grant_a  = rr_grant_a;
          bypass_n = 1'b0;
          state_n  = SETUP;
        end
      end
      SETUP: begin
        state_n = STROBE;
      end
      STROBE: begin
        inc_wcount = !bypass;
        state_n    = HOLD;
      end
      HOLD: begin
        // A bypass write returns straight to IDLE and never closes a window.
        if (bypass) begin
          state_n = IDLE;
        end else if (vsync) begin
          state_n = PICK;
        end else begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- state and outputs
  always_ff @(posedge clk_50_mhz) begin
    if (rst) begin
      state        <= IDLE;
      vsync_q      <= 1'b0;
      wcount       <= '0;
      last_grant_b <= 1'b1;
      bypass       <= 1'b0;
      wren_r       <= 1'b0;
      addr_r       <= '0;
      ldr_r        <= '0;
      frame_done_r <= 1'b0;
      backlog_r    <= 1'b0;
    end else begin
      state   <= state_n;
      vsync_q <= vsync;
      bypass  <= bypass_n;

      if (clr_wcount) begin
        wcount <= '0;
      end else if (inc_wcount && (wcount != WMAX)) begin
        wcount <= wcount + 6'd1;
      end

      // Outputs are registered from the next state so they line up with it.
      wren_r       <= (state_n == STROBE);
      frame_done_r <= (state_n == DONE);
      if (state_n == DONE) begin
        backlog_r <= !a_empty || !b_empty;
      end

      if (load) begin
        addr_r       <= grant_a ? a_head.addr : b_head.addr;
        ldr_r        <= grant_a ? a_head.data : b_head.data;
        last_grant_b <= !grant_a;
      end
    end
  end

  assign bus.wren       = wren_r;
  assign bus.addr       = addr_r;
  assign bus.ldr        = ldr_r;
  assign bus.frame_done = frame_done_r;
  assign bus.backlog    = backlog_r;
endmodule

// File: tb/tb_sprite_write_sched.sv
// Directed bench for sprite_write_sched: reset, single write timing, arbitration,
// full FIFO, per-frame budget, vsync drop mid-write and reset during STROBE.
module tb_sprite_write_sched;
  logic clk_50_mhz = 1'b0;
  logic rst;
  logic vsync;

  sprite_write_sched_if bus();

  sprite_write_sched #(
    .FIFO_DEPTH           (4),
    .MAX_WRITES_PER_FRAME (8)
  ) dut (
    .clk_50_mhz (clk_50_mhz),
    .rst        (rst),
    .vsync      (vsync),
    .bus        (bus)
  );

  always #10 clk_50_mhz = ~clk_50_mhz;

  typedef struct {
    bit          port_b;
    logic [5:0]  addr;
    logic [15:0] data;
    logic [5:0]  exp_addr;
    logic [15:0] exp_ldr;
  } vec_t;

  vec_t arb_tab [4];
  vec_t bud_tab [10];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_a = 0;
  int acc_b = 0;

  int          wr_cyc  [$];
  logic [5:0]  wr_addr [$];
  logic [15:0] wr_ldr  [$];
  int          fd_cyc  [$];
  logic        fd_bl   [$];

  always @(posedge clk_50_mhz) cyc <= cyc + 1;

  always @(negedge clk_50_mhz) begin
    if (bus.wren === 1'b1) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(bus.addr);
      wr_ldr.push_back(bus.ldr);
    end
    if (bus.frame_done === 1'b1) begin
      fd_cyc.push_back(cyc);
      fd_bl.push_back(bus.backlog);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_50_mhz);
    #1;
  endtask

  task automatic clear_mon();
    wr_cyc.delete();
    wr_addr.delete();
    wr_ldr.delete();
    fd_cyc.delete();
    fd_bl.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vsync = 1'b0;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    cycles(3);
    rst = 1'b0;
  endtask

  // Holds valid until accepted; an expired budget counts as a failed comparison.
  task automatic push(input bit pb, input logic [5:0] ad, input logic [15:0] dt);
    bit ok;
    ok = 1'b0;
    if (pb) begin
      bus.b_valid = 1'b1; bus.b_addr = ad; bus.b_data = dt;
    end else begin
      bus.a_valid = 1'b1; bus.a_addr = ad; bus.a_data = dt;
    end
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk_50_mhz);
      if ((pb ? bus.b_ready : bus.a_ready) === 1'b1) begin
        @(posedge clk_50_mhz);
        ok = 1'b1;
      end
    end
    #1;
    if (pb) bus.b_valid = 1'b0;
    else    bus.a_valid = 1'b0;
    if (ok) begin
      if (pb) acc_b++;
      else    acc_a++;
    end
    check(pb ? "push_b_accepted" : "push_a_accepted", 32'(ok), 32'd1);
  endtask

  // Compares the first n monitored writes against a table's expected columns.
  task automatic check_writes(input string tag, input int which, input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v = (which == 0) ? arb_tab[i] : bud_tab[i];
      check({tag, "_present"}, 32'(i < wr_addr.size()), 32'd1);
      if (i < wr_addr.size()) begin
        check({tag, "_addr"}, 32'(wr_addr[i]), 32'(v.exp_addr));
        check({tag, "_ldr"},  32'(wr_ldr[i]),  32'(v.exp_ldr));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  cyc_e;
    int  base;
    bit  got;

    // Arbitration: pushed A0,A1,B0,B1; written A0,B0,A1,B1.
    arb_tab[0] = '{1'b0, 6'h20, 16'd1, 6'h20, 16'd1};
    arb_tab[1] = '{1'b0, 6'h21, 16'd2, 6'h22, 16'd3};
    arb_tab[2] = '{1'b1, 6'h22, 16'd3, 6'h21, 16'd2};
    arb_tab[3] = '{1'b1, 6'h23, 16'd4, 6'h23, 16'd4};
    // Budget: A0..A5 then B0..B3 pushed; window 1 alternates up to 8 writes, window 2 gets A4,A5.
    for (int k = 0; k < 6; k++) begin
      bud_tab[k].port_b = 1'b0;
      bud_tab[k].addr   = 6'(6'h10 + k);
      bud_tab[k].data   = 16'(16'h0100 + k);
    end
    for (int k = 0; k < 4; k++) begin
      bud_tab[6 + k].port_b = 1'b1;
      bud_tab[6 + k].addr   = 6'(6'h18 + k);
      bud_tab[6 + k].data   = 16'(16'h0200 + k);
    end
    bud_tab[0].exp_addr = 6'h10; bud_tab[0].exp_ldr = 16'h0100;
    bud_tab[1].exp_addr = 6'h18; bud_tab[1].exp_ldr = 16'h0200;
    bud_tab[2].exp_addr = 6'h11; bud_tab[2].exp_ldr = 16'h0101;
    bud_tab[3].exp_addr = 6'h19; bud_tab[3].exp_ldr = 16'h0201;
    bud_tab[4].exp_addr = 6'h12; bud_tab[4].exp_ldr = 16'h0102;
    bud_tab[5].exp_addr = 6'h1a; bud_tab[5].exp_ldr = 16'h0202;
    bud_tab[6].exp_addr = 6'h13; bud_tab[6].exp_ldr = 16'h0103;
    bud_tab[7].exp_addr = 6'h1b; bud_tab[7].exp_ldr = 16'h0203;
    bud_tab[8].exp_addr = 6'h14; bud_tab[8].exp_ldr = 16'h0104;
    bud_tab[9].exp_addr = 6'h15; bud_tab[9].exp_ldr = 16'h0105;

    bus.a_addr = '0; bus.a_data = '0; bus.b_addr = '0; bus.b_data = '0;

    // ---- reset
    do_reset();
    rst = 1'b1;
    @(negedge clk_50_mhz);
    check("rst_wren",       32'(bus.wren),       32'd0);
    check("rst_addr",       32'(bus.addr),       32'd0);
    check("rst_ldr",        32'(bus.ldr),        32'd0);
    check("rst_frame_done", 32'(bus.frame_done), 32'd0);
    check("rst_backlog",    32'(bus.backlog),    32'd0);
    check("rst_a_ready",    32'(bus.a_ready),    32'd0);
    check("rst_b_ready",    32'(bus.b_ready),    32'd0);
    @(posedge clk_50_mhz); #1;
    rst = 1'b0;
    @(negedge clk_50_mhz);
    check("post_rst_a_ready", 32'(bus.a_ready), 32'd1);
    check("post_rst_b_ready", 32'(bus.b_ready), 32'd1);
    @(posedge clk_50_mhz); #1;

    // ---- single write and latency
    clear_mon();
    push(1'b0, 6'h20, 16'h0064);
    cycles(100);
    check("single_no_wren_outside_blank", 32'(wr_addr.size()), 32'd0);
    vsync = 1'b1;
    cyc_e = cyc;
    cycles(20);
    vsync = 1'b0;
    cycles(5);
    check("single_count", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() > 0) begin
      check("single_addr",    32'(wr_addr[0]), 32'h20);
      check("single_ldr",     32'(wr_ldr[0]),  32'h0064);
      check("single_latency", 32'(wr_cyc[0] - cyc_e), 32'd3);
    end
    check("single_fd_count", 32'(fd_cyc.size()), 32'd1);
    if (fd_cyc.size() > 0) begin
      check("single_fd_time", 32'(fd_cyc[0] - cyc_e), 32'd6);
      check("single_backlog", 32'(fd_bl[0]), 32'd0);
    end

    // ---- round-robin arbitration from reset
    do_reset();
    clear_mon();
    for (int i = 0; i < 4; i++) push(arb_tab[i].port_b, arb_tab[i].addr, arb_tab[i].data);
    cycles(5);
    vsync = 1'b1;
    cyc_e = cyc;
    cycles(30);
    vsync = 1'b0;
    cycles(5);
    check("arb_count", 32'(wr_addr.size()), 32'd4);
    check_writes("arb", 0, 4);
    for (int i = 0; i < 4 && i < wr_cyc.size(); i++)
      check("arb_spacing", 32'(wr_cyc[i] - cyc_e), 32'(3 + 4 * i));
    check("arb_fd_count", 32'(fd_cyc.size()), 32'd1);
    if (fd_bl.size() > 0) check("arb_backlog", 32'(fd_bl[0]), 32'd0);

    // ---- full FIFO on A
    do_reset();
    clear_mon();
    for (int i = 0; i < 4; i++) push(1'b0, 6'(6'h30 + i), 16'(16'h0030 + i));
    @(negedge clk_50_mhz);
    check("full_a_ready", 32'(bus.a_ready), 32'd0);
    check("full_b_ready", 32'(bus.b_ready), 32'd1);
    @(posedge clk_50_mhz); #1;
    base = acc_a;
    fork
      push(1'b0, 6'h34, 16'h0034);
    join_none
    cycles(50);
    check("full_fifth_held", 32'(acc_a - base), 32'd0);
    vsync = 1'b1;
    cycles(40);
    vsync = 1'b0;
    cycles(10);
    check("full_fifth_accepted", 32'(acc_a - base), 32'd1);
    check("full_count", 32'(wr_addr.size()), 32'd5);
    for (int i = 0; i < 5 && i < wr_addr.size(); i++)
      check("full_order", 32'(wr_addr[i]), 32'(6'h30 + i));
    if (fd_bl.size() > 0) check("full_backlog", 32'(fd_bl[0]), 32'd0);

    // ---- per-window budget of 8
    do_reset();
    clear_mon();
    fork
      begin
        for (int i = 0; i < 6; i++) push(1'b0, bud_tab[i].addr, bud_tab[i].data);
      end
      begin
        for (int i = 6; i < 10; i++) push(1'b1, bud_tab[i].addr, bud_tab[i].data);
      end
    join_none
    cycles(20);
    vsync = 1'b1;
    cycles(50);
    vsync = 1'b0;
    cycles(10);
    check("budget_w1_count", 32'(wr_addr.size()), 32'd8);
    check("budget_w1_fd", 32'(fd_cyc.size()), 32'd1);
    if (fd_bl.size() > 0) check("budget_w1_backlog", 32'(fd_bl[0]), 32'd1);
    vsync = 1'b1;
    cycles(20);
    vsync = 1'b0;
    cycles(5);
    check("budget_total_count", 32'(wr_addr.size()), 32'd10);
    check_writes("budget", 1, 10);
    check("budget_w2_fd", 32'(fd_cyc.size()), 32'd2);
    if (fd_bl.size() > 1) check("budget_w2_backlog", 32'(fd_bl[1]), 32'd0);

    // ---- vsync drops mid-write: current write completes, rest stays queued
    do_reset();
    clear_mon();
    push(1'b1, 6'h28, 16'h0001);
    push(1'b1, 6'h29, 16'h0002);
    vsync = 1'b1;
    cycles(2);
    vsync = 1'b0;
    cycles(15);
    check("drop_count", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() > 0) check("drop_addr", 32'(wr_addr[0]), 32'h28);
    check("drop_fd_count", 32'(fd_cyc.size()), 32'd1);
    if (fd_bl.size() > 0) check("drop_backlog", 32'(fd_bl[0]), 32'd1);

    // ---- reset during STROBE flushes everything
    push(1'b0, 6'h2a, 16'h0003);
    vsync = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_50_mhz);
      if (bus.wren === 1'b1) got = 1'b1;
    end
    check("rstmid_strobe_seen", 32'(got), 32'd1);
    rst = 1'b1;
    vsync = 1'b0;
    @(negedge clk_50_mhz);
    check("rstmid_wren",    32'(bus.wren),    32'd0);
    check("rstmid_addr",    32'(bus.addr),    32'd0);
    check("rstmid_ldr",     32'(bus.ldr),     32'd0);
    check("rstmid_a_ready", 32'(bus.a_ready), 32'd0);
    @(posedge clk_50_mhz); #1;
    rst = 1'b0;
    clear_mon();
    cycles(5);
    vsync = 1'b1;
    cycles(20);
    vsync = 1'b0;
    cycles(5);
    check("rstmid_no_writes", 32'(wr_addr.size()), 32'd0);
    check("rstmid_fd_count",  32'(fd_cyc.size()),  32'd1);
    if (fd_bl.size() > 0) check("rstmid_backlog", 32'(fd_bl[0]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sprite_write_sched.md
# sprite_write_sched

Scheduler that shares the sprite display engine's register write port (`wren`/`addr`/`ldr`) between two requesters: the CPU (port A) and the keyboard-driven game logic (port B). Each requester gets its own FIFO. Queued writes are issued only during vertical blanking, so sprite positions and bitmaps never change mid-frame. Sits between the requesters and the VGA sprite engine, clocked from `clk_50_mhz`.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: entries per requester FIFO (power of two, ≥2)
- `MAX_WRITES_PER_FRAME`, 8: write budget per blanking window (1..63)

Ports:
- `clk_50_mhz`  in  1  system clock; the only clock
- `rst`  in  1  reset; synchronous, active-high
- `vsync`  in  1  vertical sync from the display timing; same clock domain, active-high during flyback
- `a_valid`  in  1  CPU request valid
- `a_ready`  out  1  CPU FIFO can accept
- `a_addr`  in  6  CPU target register address
- `a_data`  in  16  CPU write data
- `b_valid`, `b_ready`, `b_addr`, `b_data`: same as the A ports, for game logic
- `wren`  out  1  write strobe to the sprite engine
- `addr`  out  6  register address to the sprite engine
- `ldr`  out  16  write data to the sprite engine
- `frame_done`  out  1  one-cycle pulse when a drain window closes
- `backlog`  out  1  registered at drain exit: 1 if either FIFO still holds entries

## Operation
- Handshake:
  - A request is accepted on a clock edge where `x_valid && x_ready` and `rst`=0.
  - `x_ready` = FIFO not full, and is 0 while `rst`=1.
  - A pop in the same cycle does not free space for that cycle's push.
- Blanking detect: `vsync_q` is `vsync` registered; `blank_rise` = `vsync && !vsync_q`.
- FSM:
  - IDLE: waits for `blank_rise`, then clears `wcount`. Goes to PICK.
  - PICK: if both FIFOs are empty or `wcount == MAX_WRITES_PER_FRAME`, goes to DONE. Otherwise it grants one FIFO, pops its head into the `addr`/`ldr` registers and goes to SETUP.
    - Grant is round-robin: if both FIFOs are non-empty, grant goes to the one not granted last.
    - `last_grant` resets to B, so A wins the first tie.
  - SETUP: `wren`=0, `addr`/`ldr` stable. Goes to STROBE.
  - STROBE: `wren`=1 for exactly one cycle; `wcount`++. Goes to HOLD.
  - HOLD: `wren`=0, `addr`/`ldr` held. Goes to PICK if `vsync`=1, else DONE.
  - DONE: `frame_done`=1 for one cycle and `backlog` is updated. Goes to IDLE.
- The write pulse is surrounded by one idle cycle on each side because the sprite engine latches on the `wren` edge.
- If `vsync` falls mid-write, the current SETUP/STROBE/HOLD completes. Remaining entries stay queued for the next frame.
- A `blank_rise` seen outside IDLE is ignored.
- `wcount` is 6 bits and saturates at `MAX_WRITES_PER_FRAME`.
- Each FIFO is a circular buffer with `log2(FIFO_DEPTH)+1`-bit pointers; full/empty are decided by the MSB comparison. Order is preserved per requester.

## Timing
- Reset values: `wren`=0, `addr`=0, `ldr`=0, `frame_done`=0, `backlog`=0, `a_ready`=`b_ready`=0 during `rst`, FIFOs empty, state IDLE, `last_grant`=B.
- `rst` asserted in any state: the next edge forces the reset values (`wren` drops immediately) and flushes all queued data.
- Latency from the `vsync` rising edge (edge E, where `vsync_q` is still 0):
  - PICK at E+1
  - SETUP at E+2
  - `wren`=1 during the cycle after edge E+3
- Throughput: one write per 4 cycles (PICK, SETUP, STROBE, HOLD).
- Worst-case drain of 63 writes takes 252 cycles, well inside the 3200-cycle vsync window.
- Accepted requests become visible to PICK on the next cycle.

## Configuration
- `SPRITE_SCHED_BITMAP_BYPASS_EN` defined:
  - In IDLE, if a FIFO head has `addr < 6'h10`, that entry is issued immediately via SETUP/STROBE/HOLD, even outside blanking, then the FSM returns to IDLE.
  - Position and planet registers (`addr >= 6'h10`) still wait for blanking.
  - Bypass writes do not count toward `wcount` and do not pulse `frame_done`.
- Not defined: every write waits for blanking.

## Test plan
- Reset: drive `rst` for 3 cycles → `wren`/`addr`/`ldr`/`frame_done`=0 and `a_ready`=`b_ready`=0; one cycle after release, both ready signals read 1.
- Single write: push A (`6'h20`, `16'h0064`) with `vsync`=0 for 100 cycles → no `wren`. Raise `vsync` at E → `addr`=`6'h20`, `ldr`=`16'h0064`, `wren` high for exactly 1 cycle after edge E+3, then `frame_done` pulses with `backlog`=0.
- Arbitration: push A0=(`6'h20`,1), A1=(`6'h21`,2), B0=(`6'h22`,3), B1=(`6'h23`,4) → `wren` order A0, B0, A1, B1, spaced 4 cycles apart.
- Full: push 4 entries to A → `a_ready`=0; a 5th held valid is not accepted until after the drain; a later drain writes the 5th.
- Budget: queue 6 on A and 4 on B with `MAX_WRITES_PER_FRAME`=8 → 8 writes this window, `backlog`=1; the next window writes the remaining 2 and sets `backlog`=0.
- Reset mid-op: assert `rst` during STROBE → `wren`=0 next cycle, both FIFOs empty, and no writes on the next `vsync`.
